// File: rtl/fft4_pkg.sv
// -----------------------------------------------------------------------------
// fft4_pkg
// Shared types and constants for the 4-point DFT engine.
//   state_t    : engine state (LOAD, MAC, EMIT)
//   FFT_N      : transform length (4)
//   FFT_LOG2N  : counter width for sample / bin indices (2)
//   PROD_W     : complex product component width for the default widths
//   ACC_W      : accumulator component width for the default widths
//   tw_index() : twiddle exponent (k*n) mod N
// Optional build macro used by the engine: DFT4_SAT_EN (saturating output).
// -----------------------------------------------------------------------------
package fft4_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam int FFT_N     = 4;
  localparam int FFT_LOG2N = 2;

  localparam int DEF_BIT_WIDTH = 4;
  localparam int DEF_W_WIDTH   = 4;

  // One extra bit for the sum of two products, two more for four terms.
  localparam int PROD_W = DEF_BIT_WIDTH + DEF_W_WIDTH + 1;
  localparam int ACC_W  = DEF_BIT_WIDTH + DEF_W_WIDTH + 3;

  // Because N is a power of two, keeping the low bits of k*n is the modulo.
  function automatic logic [FFT_LOG2N-1:0] tw_index(input logic [FFT_LOG2N-1:0] k,
                                                    input logic [FFT_LOG2N-1:0] n);
    return FFT_LOG2N'(k * n);
  endfunction

endpackage

// File: rtl/dft4_engine_cmul_4.sv
// -----------------------------------------------------------------------------
// cmul_4
// Combinational full-precision signed complex multiplier.
//   x_re, x_im   : sample components (BIT_WIDTH, signed)
//   w_re, w_im   : twiddle components (W_WIDTH, signed)
//   prod_re      : x_re*w_re - x_im*w_im (PROD_W, signed)
//   prod_im      : x_re*w_im + x_im*w_re (PROD_W, signed)
// -----------------------------------------------------------------------------
module cmul_4 #(
  parameter int BIT_WIDTH = 4,
  parameter int W_WIDTH   = 4,
  parameter int PROD_W    = BIT_WIDTH + W_WIDTH + 1
) (
  input  logic signed [BIT_WIDTH-1:0] x_re,
  input  logic signed [BIT_WIDTH-1:0] x_im,
  input  logic signed [W_WIDTH-1:0]   w_re,
  input  logic signed [W_WIDTH-1:0]   w_im,
  output logic signed [PROD_W-1:0]    prod_re,
  output logic signed [PROD_W-1:0]    prod_im
);

  // Sign-extend everything to the result width first; the true result always
  // fits in PROD_W bits, so the modular PROD_W-bit arithmetic is exact.
  logic signed [PROD_W-1:0] xr_e, xi_e, wr_e, wi_e;

  assign xr_e = {{(PROD_W-BIT_WIDTH){x_re[BIT_WIDTH-1]}}, x_re};
  assign xi_e = {{(PROD_W-BIT_WIDTH){x_im[BIT_WIDTH-1]}}, x_im};
  assign wr_e = {{(PROD_W-W_WIDTH){w_re[W_WIDTH-1]}}, w_re};
  assign wi_e = {{(PROD_W-W_WIDTH){w_im[W_WIDTH-1]}}, w_im};

  assign prod_re = xr_e * wr_e - xi_e * wi_e;
  assign prod_im = xr_e * wi_e + xi_e * wr_e;

endmodule

// File: rtl/dft4_engine.sv
// -----------------------------------------------------------------------------
// dft4_engine
// Sequential 4-point DFT: loads four complex samples, then computes each bin
// X[k] = sum_n x[n] * W^((k*n) mod 4) with one complex MAC per cycle, reading
// the twiddle from an external asynchronous ROM, and streams the bins out.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : sample handshake, in_re/in_im samples n=0..3
//   tw_addr              : twiddle ROM address ((k*n) mod 4, zero outside MAC)
//   tw_re/tw_im          : twiddle returned by the ROM in the same cycle
//   out_valid/out_ready  : bin handshake
//   out_re/out_im        : X[k] scaled by 2^-(W_WIDTH-1) (floor)
//   out_bin, out_last    : bin index k, high with bin 3
// Build macro DFT4_SAT_EN: saturate the scaled result to OUT_WIDTH instead of
// wrapping it.
// -----------------------------------------------------------------------------
module dft4_engine
  import fft4_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int W_WIDTH   = 4,
  parameter int TW_ADDR_W = 4,
  parameter int OUT_WIDTH = BIT_WIDTH + 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] in_re,
  input  logic signed [BIT_WIDTH-1:0] in_im,
  output logic [TW_ADDR_W-1:0]        tw_addr,
  input  logic signed [W_WIDTH-1:0]   tw_re,
  input  logic signed [W_WIDTH-1:0]   tw_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_re,
  output logic signed [OUT_WIDTH-1:0] out_im,
  output logic [1:0]                  out_bin,
  output logic                        out_last
);

  // Package widths are for the default sizes; rescale for these parameters.
  localparam int PW = PROD_W + (BIT_WIDTH - DEF_BIT_WIDTH) + (W_WIDTH - DEF_W_WIDTH);
  localparam int AW = ACC_W  + (BIT_WIDTH - DEF_BIT_WIDTH) + (W_WIDTH - DEF_W_WIDTH);
  localparam logic [FFT_LOG2N-1:0] LAST_IDX = FFT_LOG2N'(FFT_N - 1);

`ifdef DFT4_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  state_t                      state_q, state_d;
  logic [FFT_LOG2N-1:0]        ld_cnt_q, ld_cnt_d;
  logic [FFT_LOG2N-1:0]        k_q, k_d;
  logic [FFT_LOG2N-1:0]        n_q, n_d;
  logic signed [BIT_WIDTH-1:0] samp_re_q [FFT_N];
  logic signed [BIT_WIDTH-1:0] samp_re_d [FFT_N];
  logic signed [BIT_WIDTH-1:0] samp_im_q [FFT_N];
  logic signed [BIT_WIDTH-1:0] samp_im_d [FFT_N];
  logic signed [AW-1:0]        acc_re_q, acc_re_d;
  logic signed [AW-1:0]        acc_im_q, acc_im_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [FFT_LOG2N-1:0]        out_bin_q, out_bin_d;
  logic signed [OUT_WIDTH-1:0] out_re_q, out_re_d;
  logic signed [OUT_WIDTH-1:0] out_im_q, out_im_d;

  logic signed [PW-1:0]        prod_re, prod_im;
  logic signed [AW-1:0]        acc_sum_re, acc_sum_im;

  // Scale back from Q1.(W_WIDTH-1) twiddles; >>> on a signed value is floor.
  function automatic logic signed [OUT_WIDTH-1:0] scale(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] sh;
    sh = a >>> (W_WIDTH - 1);
`ifdef DFT4_SAT_EN
    if (sh > SAT_MAX) begin
      return OUT_WIDTH'(SAT_MAX);
    end else if (sh < SAT_MIN) begin
      return OUT_WIDTH'(SAT_MIN);
    end
    return OUT_WIDTH'(sh);
`else
    return OUT_WIDTH'(sh);
`endif
  endfunction

  // Twiddle path is purely combinational: tw_addr -> ROM -> multiplier -> acc.
  cmul_4 #(
    .BIT_WIDTH (BIT_WIDTH),
    .W_WIDTH   (W_WIDTH),
    .PROD_W    (PW)
  ) u_cmul (
    .x_re    (samp_re_q[n_q]),
    .x_im    (samp_im_q[n_q]),
    .w_re    (tw_re),
    .w_im    (tw_im),
    .prod_re (prod_re),
    .prod_im (prod_im)
  );

  assign acc_sum_re = acc_re_q + {{(AW-PW){prod_re[PW-1]}}, prod_re};
  assign acc_sum_im = acc_im_q + {{(AW-PW){prod_im[PW-1]}}, prod_im};

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    k_d         = k_q;
    n_d         = n_q;
    samp_re_d   = samp_re_q;
    samp_im_d   = samp_im_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_bin_d   = out_bin_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          samp_re_d[ld_cnt_q] = in_re;
          samp_im_d[ld_cnt_q] = in_im;
          ld_cnt_d            = ld_cnt_q + FFT_LOG2N'(1);
          if (ld_cnt_q == LAST_IDX) begin
            ld_cnt_d = '0;
            k_d      = '0;
            n_d      = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            state_d  = MAC;
          end
        end
      end

      MAC: begin
        acc_re_d = acc_sum_re;
        acc_im_d = acc_sum_im;
        if (n_q == LAST_IDX) begin
          // Final term lands this cycle: capture the bin straight from the sum.
          out_re_d    = scale(acc_sum_re);
          out_im_d    = scale(acc_sum_im);
          out_bin_d   = k_q;
          out_last_d  = (k_q == LAST_IDX);
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          n_d = n_q + FFT_LOG2N'(1);
        end
      end

      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (k_q == LAST_IDX) begin
            state_d = LOAD;
          end else begin
            k_d      = k_q + FFT_LOG2N'(1);
            n_d      = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            state_d  = MAC;
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      ld_cnt_q    <= '0;
      k_q         <= '0;
      n_q         <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bin_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      for (int i = 0; i < FFT_N; i++) begin
        samp_re_q[i] <= '0;
        samp_im_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      k_q         <= k_d;
      n_q         <= n_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bin_q   <= out_bin_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      samp_re_q   <= samp_re_d;
      samp_im_q   <= samp_im_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign tw_addr   = (state_q == MAC) ? TW_ADDR_W'(tw_index(k_q, n_q)) : '0;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_bin   = out_bin_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_dft4_engine.sv
// -----------------------------------------------------------------------------
// tb_dft4_engine
// Self-checking bench for dft4_engine with a behavioural DFT reference model
// and the default asynchronous 4-entry twiddle ROM.
// Honours DFT4_SAT_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_dft4_engine;
  import fft4_pkg::*;

  localparam int BW = 4;
  localparam int WW = 4;
  localparam int AW_ADDR = 4;
  localparam int OW = BW + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] in_re, in_im;
  logic [AW_ADDR-1:0]   tw_addr;
  logic signed [WW-1:0] tw_re, tw_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re, out_im;
  logic [1:0]           out_bin;
  logic                 out_last;

  int n_tests = 0;
  int n_fail  = 0;

  // Default ROM: W^m = exp(-j*2*pi*m/4) in Q1.3 (+1 -> 7, -1 -> -8).
  int rom_re [FFT_N] = '{7, 0, -8, 0};
  int rom_im [FFT_N] = '{0, -8, 0, 7};

  int xr [FFT_N];
  int xi [FFT_N];
  int exp_re [FFT_N];
  int exp_im [FFT_N];

  dft4_engine #(
    .BIT_WIDTH (BW),
    .W_WIDTH   (WW),
    .TW_ADDR_W (AW_ADDR),
    .OUT_WIDTH (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_addr   (tw_addr),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_bin   (out_bin),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always_comb begin
    tw_re = '0;
    tw_im = '0;
    case (tw_addr)
      4'd0: begin tw_re = 4'sd7;  tw_im = 4'sd0;  end
      4'd1: begin tw_re = 4'sd0;  tw_im = -4'sd8; end
      4'd2: begin tw_re = -4'sd8; tw_im = 4'sd0;  end
      4'd3: begin tw_re = 4'sd0;  tw_im = 4'sd7;  end
      default: begin tw_re = '0; tw_im = '0; end
    endcase
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int floor_div8(input int a);
    int q;
    q = a / 8;
    if ((a % 8) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int fit_out(input int v);
    int lim;
    lim = 1 << (OW - 1);
`ifdef DFT4_SAT_EN
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
`else
    return ((v + lim) % (2 * lim) + 2 * lim) % (2 * lim) - lim;
`endif
  endfunction

  // Direct DFT from the definition using the ROM table.
  task automatic model_frame();
    for (int k = 0; k < FFT_N; k++) begin
      int ar, ai, m;
      ar = 0;
      ai = 0;
      for (int n = 0; n < FFT_N; n++) begin
        m = (k * n) % FFT_N;
        ar += xr[n] * rom_re[m] - xi[n] * rom_im[m];
        ai += xr[n] * rom_im[m] + xi[n] * rom_re[m];
      end
      exp_re[k] = fit_out(floor_div8(ar));
      exp_im[k] = fit_out(floor_div8(ai));
    end
  endtask

  task automatic set_frame(input int r0, input int r1, input int r2, input int r3,
                           input int i0, input int i1, input int i2, input int i3);
    xr[0] = r0; xr[1] = r1; xr[2] = r2; xr[3] = r3;
    xi[0] = i0; xi[1] = i1; xi[2] = i2; xi[3] = i3;
    model_frame();
  endtask

  task automatic rand_frame();
    for (int n = 0; n < FFT_N; n++) begin
      xr[n] = int'($urandom_range(15)) - 8;
      xi[n] = int'($urandom_range(15)) - 8;
    end
    model_frame();
  endtask

  // Returns right after the 4th accepting edge, so the next negedge is MAC cycle 1.
  task automatic send_frame();
    for (int n = 0; n < FFT_N; n++) begin
      @(negedge clk);
      check($sformatf("in_ready_load%0d", n), int'(in_ready), 1);
      in_valid = 1'b1;
      in_re    = BW'(xr[n]);
      in_im    = BW'(xi[n]);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv_bin(input int k, input bit stall);
    int q[$];
    int budget;
    budget = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && budget < 20) begin
      q.push_back(int'(tw_addr));
      budget++;
      @(negedge clk);
    end
    check($sformatf("bin%0d_valid", k), int'(out_valid), 1);
    check($sformatf("bin%0d_mac_cycles", k), q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++)
      check($sformatf("bin%0d_tw_addr%0d", k, i), q[i], (k * i) % FFT_N);
    check($sformatf("bin%0d_tw_idle", k), int'(tw_addr), 0);
    check($sformatf("bin%0d_in_ready", k), int'(in_ready), 0);
    check($sformatf("bin%0d_index", k), int'(out_bin), k);
    check($sformatf("bin%0d_last", k), int'(out_last), (k == 3) ? 1 : 0);
    check($sformatf("bin%0d_re", k), int'(out_re), exp_re[k]);
    check($sformatf("bin%0d_im", k), int'(out_im), exp_im[k]);
    $display("[TB] bin %0d: re=%0d im=%0d (model %0d,%0d)", k, out_re, out_im,
             exp_re[k], exp_im[k]);
    if (stall) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_re     = 4'sd5;
      in_im     = -4'sd3;
      repeat (10) begin
        @(negedge clk);
        check("stall_valid", int'(out_valid), 1);
        check("stall_re", int'(out_re), exp_re[k]);
        check("stall_im", int'(out_im), exp_im[k]);
        check("stall_bin", int'(out_bin), k);
        check("stall_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic run_frame(input string name, input int stall_bin);
    $display("[TB] frame %s", name);
    send_frame();
    for (int k = 0; k < FFT_N; k++) recv_bin(k, k == stall_bin);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_tw_addr", int'(tw_addr), 0);
    check("rst_out_re", int'(out_re), 0);
    check("rst_out_im", int'(out_im), 0);
    check("rst_out_bin", int'(out_bin), 0);
    check("rst_out_last", int'(out_last), 0);
    rst_n = 1'b1;

    set_frame(4, 0, 0, 0, 0, 0, 0, 0);
    run_frame("impulse", -1);
    set_frame(4, 4, 4, 4, 0, 0, 0, 0);
    run_frame("dc", -1);
    set_frame(7, -8, 7, -8, 0, 0, 0, 0);
    run_frame("extremes", -1);
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      run_frame("random", -1);
    end

    // Backpressure on bin 1 with samples offered while stalled.
    set_frame(4, 4, 4, 4, 0, 0, 0, 0);
    run_frame("dc_backpressure", 1);

    // Reset during MAC of bin 2.
    set_frame(4, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] frame reset_mid_mac");
    send_frame();
    recv_bin(0, 1'b0);
    recv_bin(1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rmac_out_valid", int'(out_valid), 0);
    check("rmac_in_ready", int'(in_ready), 1);
    check("rmac_tw_addr", int'(tw_addr), 0);
    check("rmac_out_bin", int'(out_bin), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("impulse_after_reset", -1);

    // Reset while a bin is pending in EMIT: out_valid must drop at once.
    set_frame(4, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] frame reset_in_emit");
    send_frame();
    recv_bin(0, 1'b0);
    out_ready = 1'b0;
    begin
      int budget;
      budget = 0;
      while (out_valid !== 1'b1 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
    end
    check("remit_valid_before", int'(out_valid), 1);
    check("remit_re_before", int'(out_re), exp_re[1]);
    rst_n = 1'b0;
    #1;
    check("remit_out_valid", int'(out_valid), 0);
    check("remit_out_re", int'(out_re), 0);
    check("remit_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("impulse_after_reset2", -1);

    for (int f = 0; f < 3; f++) begin
      rand_frame();
      run_frame("random_tail", -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
